// File: rtl/rom_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rom_fetch_pkg
//  Description : Shared types and constants for the ROM burst reader:
//                FSM state encoding, buffered-word record, and the legal
//                ranges for ROM latency and output buffer depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package rom_fetch_pkg;

    localparam int C_DATA_WIDTH          = 16;
    localparam int C_ADDR_WIDTH          = 8;
    localparam int C_LEN_WIDTH           = 8;

    localparam int C_ROM_LATENCY_MIN     = 1;
    localparam int C_ROM_LATENCY_MAX     = 3;
    localparam int C_ROM_LATENCY_DEFAULT = 1;
    localparam int C_FIFO_DEPTH_DEFAULT  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One buffered ROM word with the address it came from and its error tag
    typedef struct packed {
        logic [C_DATA_WIDTH-1:0] data;
        logic [C_ADDR_WIDTH-1:0] addr;
        logic                    err;
    } fifo_entry_t;

    // Depth must be a power of two and must cover every word that can be in
    // flight when the buffer is otherwise full.
    function automatic bit cfg_ok(input int depth, input int latency);
        return (latency >= C_ROM_LATENCY_MIN) && (latency <= C_ROM_LATENCY_MAX) &&
               (depth >= latency + 1) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rom_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : rom_fetch_if
//  Description : ROM data port plus the valid/ready output word stream.
//                master = the reader, slave = ROM + downstream consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rom_fetch_if;
    import rom_fetch_pkg::*;

    logic [C_ADDR_WIDTH-1:0] rom_addr;
    logic                    rom_en;
    logic [C_DATA_WIDTH-1:0] rom_data;
    logic                    rom_error;

    logic                    out_valid;
    logic                    out_ready;
    logic [C_DATA_WIDTH-1:0] out_data;
    logic [C_ADDR_WIDTH-1:0] out_addr;
    logic                    out_err;

    modport master (
        output rom_addr, rom_en,
        input  rom_data, rom_error,
        output out_valid, out_data, out_addr, out_err,
        input  out_ready
    );

    modport slave (
        input  rom_addr, rom_en,
        output rom_data, rom_error,
        input  out_valid, out_data, out_addr, out_err,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/rom_fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rom_fetch_fifo
//  Description : Small synchronous FIFO. Head word is read straight from
//                storage flops, so a push is visible on the next cycle.
//                Push and pop in the same cycle are allowed even when full.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_fetch_fifo
    import rom_fetch_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_push,
    input  fifo_entry_t               i_entry,
    input  wire logic                 i_pop,
    output fifo_entry_t               o_entry,
    output logic                      o_valid,
    output logic [CNT_WIDTH-1:0]      o_count
);

    localparam int PTR_WIDTH = $clog2(DEPTH);

    fifo_entry_t            r_mem [DEPTH];
    logic [PTR_WIDTH-1:0]   r_wr_ptr;
    logic [PTR_WIDTH-1:0]   r_rd_ptr;
    logic [CNT_WIDTH-1:0]   r_count;
    logic                   w_pop;

    // A pop on an empty FIFO is ignored
    assign w_pop = i_pop && (r_count != '0);

    // Storage, pointers and occupancy; storage is cleared so an empty head reads zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_entry;
                r_wr_ptr        <= r_wr_ptr + PTR_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
            end
            r_count <= r_count + CNT_WIDTH'(i_push) - CNT_WIDTH'(w_pop);
        end
    end

    assign o_entry = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/rom_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : rom_fetch
//  Description : Burst reader for the project ROM. Issues consecutive
//                addresses under a credit scheme, tracks the fixed ROM read
//                latency, buffers returned words and streams them out over
//                valid/ready with the source address and error tag.
//  Options     : ROM_FETCH_ERR_ABORT_EN - stop issuing after the first word
//                returned with rom_error set (in-flight words still drain).
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_fetch
    import rom_fetch_pkg::*;
#(
    parameter int ROM_LATENCY = C_ROM_LATENCY_DEFAULT,
    parameter int FIFO_DEPTH  = C_FIFO_DEPTH_DEFAULT
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    i_start,
    input  wire logic [C_ADDR_WIDTH-1:0] i_base_addr,
    input  wire logic [C_LEN_WIDTH-1:0]  i_length,
    rom_fetch_if.master                  bus,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_err_flag
);

    localparam int FIFO_CNT_WIDTH = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_WIDTH      = $clog2(FIFO_DEPTH + ROM_LATENCY + 2) + 1;

    if (!cfg_ok(FIFO_DEPTH, ROM_LATENCY)) begin : g_param_check
        $error("rom_fetch: illegal ROM_LATENCY / FIFO_DEPTH combination");
    end

    state_t                     r_state;
    logic                       r_rom_en;
    logic [C_ADDR_WIDTH-1:0]    r_rom_addr;
    logic [C_ADDR_WIDTH-1:0]    r_next_addr;
    logic [C_LEN_WIDTH-1:0]     r_remaining;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_err_flag;

    logic                       r_pipe_v    [ROM_LATENCY];
    logic [C_ADDR_WIDTH-1:0]    r_pipe_addr [ROM_LATENCY];

    fifo_entry_t                w_push_entry;
    fifo_entry_t                w_fifo_out;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_fifo_valid;
    logic [FIFO_CNT_WIDTH-1:0]  w_fifo_count;
    logic [CNT_WIDTH-1:0]       w_inflight;
    logic [CNT_WIDTH-1:0]       w_total_next;
    logic                       w_credit;
    logic                       w_push_err;
    logic                       w_abort;

    // The oldest pipeline stage lines up with the ROM's returned word
    assign w_push       = r_pipe_v[ROM_LATENCY-1];
    assign w_push_entry = '{data: bus.rom_data,
                            addr: r_pipe_addr[ROM_LATENCY-1],
                            err:  bus.rom_error};
    assign w_push_err   = w_push && bus.rom_error;
    assign w_pop        = w_fifo_valid && bus.out_ready;

`ifdef ROM_FETCH_ERR_ABORT_EN
    assign w_abort = w_push_err;
`else
    assign w_abort = 1'b0;
`endif

    // Words already committed: the one on the ROM port plus every pipeline stage
    always_comb begin
        w_inflight = CNT_WIDTH'(r_rom_en);
        for (int i = 0; i < ROM_LATENCY; i++) begin
            w_inflight = w_inflight + CNT_WIDTH'(r_pipe_v[i]);
        end
    end

    // Buffer slots that will be spoken for after this edge; issuing next cycle
    // is only safe while this stays below the depth.
    assign w_total_next = CNT_WIDTH'(w_fifo_count) - CNT_WIDTH'(w_pop) + w_inflight;
    assign w_credit     = (w_total_next < CNT_WIDTH'(FIFO_DEPTH));

    // Latency tracker: shift the issued {valid, addr} toward the capture point
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROM_LATENCY; i++) begin
                r_pipe_v[i]    <= 1'b0;
                r_pipe_addr[i] <= '0;
            end
        end else begin
            r_pipe_v[0]    <= r_rom_en;
            r_pipe_addr[0] <= r_rom_addr;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                r_pipe_v[i]    <= r_pipe_v[i-1];
                r_pipe_addr[i] <= r_pipe_addr[i-1];
            end
        end
    end

    // Burst control FSM; all handshake outputs are registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rom_en    <= 1'b0;
            r_rom_addr  <= '0;
            r_next_addr <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_flag  <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_rom_en <= 1'b0;
            if (w_push_err) begin
                r_err_flag <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_err_flag <= 1'b0;
                        if (i_length == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            // Buffer is empty in IDLE, so the first issue needs no credit check
                            r_busy      <= 1'b1;
                            r_rom_en    <= 1'b1;
                            r_rom_addr  <= i_base_addr;
                            r_next_addr <= i_base_addr + C_ADDR_WIDTH'(1);
                            r_remaining <= i_length - C_LEN_WIDTH'(1);
                            r_state     <= (i_length == C_LEN_WIDTH'(1)) ? ST_DRAIN : ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (w_abort) begin
                        r_state <= ST_DRAIN;
                    end else if (w_credit) begin
                        r_rom_en    <= 1'b1;
                        r_rom_addr  <= r_next_addr;
                        r_next_addr <= r_next_addr + C_ADDR_WIDTH'(1);
                        r_remaining <= r_remaining - C_LEN_WIDTH'(1);
                        if (r_remaining == C_LEN_WIDTH'(1)) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Finish once nothing is in flight and the last word leaves this cycle
                    if (w_total_next == '0) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    rom_fetch_fifo #(
        .DEPTH     (FIFO_DEPTH),
        .CNT_WIDTH (FIFO_CNT_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .o_entry (w_fifo_out),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_count)
    );

    assign bus.rom_en    = r_rom_en;
    assign bus.rom_addr  = r_rom_addr;
    assign bus.out_valid = w_fifo_valid;
    assign bus.out_data  = w_fifo_out.data;
    assign bus.out_addr  = w_fifo_out.addr;
    assign bus.out_err   = w_fifo_out.err;

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err_flag = r_err_flag;

endmodule
`default_nettype wire

// File: doc/rom_fetch.md
# rom_fetch

Sequential reader for the project ROM: on a start pulse it issues a burst of consecutive addresses, tracks the ROM's fixed read latency, captures each returned word together with the ROM error flag, and hands words to a downstream consumer over a valid/ready stream. It sits between the ROM data port and the fetch/decode side of the RISC-V core. A small skid FIFO provides back-pressure so the ROM is never asked for data that has nowhere to go.

## Interface
- data_width, 16, ROM word width
- addr_width, 8, ROM address width
- len_width, 8, burst length counter width
- rom_latency, 1, cycles from rom_addr presented to rom_data/rom_error valid (1..3)
- fifo_depth, 4, output buffer entries (power of 2, >= rom_latency + 1)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle burst request, accepted only in IDLE
- base_addr  in  addr_width  first address of burst, sampled with start
- length  in  len_width  number of words, sampled with start
- rom_addr  out  addr_width  address to ROM
- rom_en  out  1  address valid this cycle
- rom_data  in  data_width  ROM read data
- rom_error  in  1  ROM error, aligned with rom_data
- out_valid  out  1  out_data/out_addr/out_err valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_data  out  data_width  fetched word
- out_addr  out  addr_width  address the word came from
- out_err  out  1  rom_error captured with that word
- busy  out  1  high from start accept until done
- done  out  1  one-cycle pulse when burst complete
- err_flag  out  1  sticky: any word in last burst had error; cleared on next start

## Operation
- FSM: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start=1 latches base_addr, length; length=0 goes directly to DONE; else ISSUE. start outside IDLE ignored.
- ISSUE: rom_en=1 with rom_addr=next address when credit available; credit = fifo_depth − (fifo occupancy + words in flight) > 0. Each issue increments address (mod 2^addr_width, wraps 0xFF→0x00 at default) and decrements remaining. After last issue → DRAIN.
- In-flight tracking: rom_latency-deep shift register of {valid, addr}; on exit, {rom_data, rom_error, addr} pushed into FIFO.
- DRAIN: wait until in-flight empty and FIFO empty → DONE.
- DONE: done=1 for one cycle, busy=0, → IDLE.
- err_flag set on any pushed word with rom_error=1.
- Simultaneous FIFO push and pop when full: allowed (pop frees slot same cycle); credit logic guarantees push never overflows.
- Reset at any time: FSM to IDLE, FIFO and in-flight pipeline flushed, returning words discarded.

## Timing
- Reset values: rom_addr=0, rom_en=0, out_valid=0, out_data=0, out_addr=0, out_err=0, busy=0, done=0, err_flag=0.
- start at cycle t → first rom_en at t+1; word appears on out_valid at t+1+rom_latency+1 (FIFO registered output).
- Steady state with out_ready=1: one word per cycle.
- out_valid, once high, holds data stable until accepted.
- done asserted the cycle after last word is popped.

## Configuration
- ROM_FETCH_ERR_ABORT_EN defined: first word with rom_error=1 stops further issue; already in-flight words are still captured and delivered; FSM → DRAIN → DONE with err_flag=1.
- Undefined: errors only tag words (out_err) and set err_flag; burst runs to full length.

## Structure
- rom_fetch_pkg: FSM state enum, fifo entry struct {data, addr, err}, latency/depth limit constants.
- Sub-module rom_fetch_fifo: synchronous FIFO with registered output, occupancy count, push/pop same cycle.

## Test plan
- base_addr=0x10, length=4, ROM data=addr^0xA5A5, out_ready=1 → words 0xA5B5,0xA5B4,0xA5B7,0xA5B6 at addrs 0x10–0x13, done once, err_flag=0.
- base_addr=0xFE, length=4 → out_addr sequence 0xFE,0xFF,0x00,0x01.
- length=8, out_ready=0 for 20 cycles then 1 → rom_en stops after fifo_depth issues, no lost/duplicate words, order preserved.
- rom_error=1 on 3rd word of length=6 → with ROM_FETCH_ERR_ABORT_EN fewer than 6 words, out_err on 3rd, err_flag=1; without macro all 6 delivered, only 3rd tagged.
- length=0 → done pulse 1 cycle after start, no rom_en, no out_valid.
- rst asserted mid-burst (after 2 words) → all outputs to reset values immediately; new start afterwards yields clean burst.
